// File: rtl/full_adder_32bit.sv
// full_adder_32bit: 32-bit adder with carry-in, carry-out and signed overflow.
// Eight 4-bit carry-lookahead groups of full-adder cells. Each group passes
// its carry-out to the next group.
// Build option FULL_ADDER_32BIT_REG_OUT_EN adds a registered output stage with
// synchronous active-high reset. Without it, the outputs are purely
// combinational and clk/reset have no effect.

// One bit cell: produces the sum bit and the generate/propagate terms.
// The group's lookahead logic builds the carries from these terms.
module full_adder_32bit_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic g,
    output logic p
);
    assign p = a ^ b;
    assign g = a & b;
    assign s = p ^ c;
endmodule

// 4-bit carry-lookahead group. Every internal carry is expanded directly from
// c_in, so no carry ripples through the group.
module full_adder_32bit_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic [4:0] c
);
    logic [3:0] g;
    logic [3:0] p;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        full_adder_32bit_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .c (c[i]),
            .s (s[i]),
            .g (g[i]),
            .p (p[i])
        );
    end

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);
endmodule

module full_adder_32bit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inp0,
    input  logic [31:0] inp1,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        carry,
    output logic        overflow
);
    logic [31:0] sum_comb;
    logic        carry_comb;
    logic        overflow_comb;

    // Group carry-ins are separate per-group nets, so each group's carry-out
    // feeds only the next group. This keeps the ripple chain free of loops.
    for (genvar k = 0; k < 8; k++) begin : g_grp
        logic       c_in;
        logic [4:0] c;
        if (k == 0) begin : g_first
            assign c_in = cin;
        end else begin : g_next
            assign c_in = g_grp[k-1].c[4];
        end
        full_adder_32bit_cla4 u_cla (
            .a    (inp0[4*k +: 4]),
            .b    (inp1[4*k +: 4]),
            .c_in (c_in),
            .s    (sum_comb[4*k +: 4]),
            .c    (c)
        );
    end

    assign carry_comb    = g_grp[7].c[4];
    assign overflow_comb = g_grp[7].c[4] ^ g_grp[7].c[3];

`ifdef FULL_ADDER_32BIT_REG_OUT_EN
    // Output register: reset clears all outputs; otherwise capture the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum      <= 32'd0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sum      <= sum_comb;
            carry    <= carry_comb;
            overflow <= overflow_comb;
        end
    end
`else
    logic unused_clk_reset;
    assign unused_clk_reset = clk | reset;

    assign sum      = sum_comb;
    assign carry    = carry_comb;
    assign overflow = overflow_comb;
`endif
endmodule

// File: tb/tb_full_adder_32bit.sv
// Self-checking bench for full_adder_32bit.
// A table of vectors and random operands are checked against expected results
// held in a scoreboard queue. When FULL_ADDER_32BIT_REG_OUT_EN is defined,
// the bench also checks reset and the one-cycle output latency.
module tb_full_adder_32bit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inp0 = '0;
    logic [31:0] inp1 = '0;
    logic        cin = 1'b0;
    logic [31:0] sum;
    logic        carry;
    logic        overflow;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] exp_sum;
        logic        exp_carry;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] exp_sum;
        logic        exp_carry;
        logic        exp_ovf;
    } exp_t;

    exp_t  scoreboard[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    vec_t  table_vec[11];

    full_adder_32bit dut (
        .clk      (clk),
        .reset    (reset),
        .inp0     (inp0),
        .inp1     (inp1),
        .cin      (cin),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: 33-bit add, with signed overflow taken from the operand and result signs.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
        exp_t        e;
        logic [32:0] full;
        full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        e.exp_sum   = full[31:0];
        e.exp_carry = full[32];
        e.exp_ovf   = (a[31] == b[31]) && (full[31] != a[31]);
        return e;
    endfunction

    // Drive operands on a falling edge and queue the expected result.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                 input exp_t e);
        @(negedge clk);
        inp0 = a;
        inp1 = b;
        cin  = ci;
        scoreboard.push_back(e);
    endtask

    // Wait for the design's latency, then compare against the oldest queued result.
    task automatic checkOutput(input string name);
        exp_t e;
`ifdef FULL_ADDER_32BIT_REG_OUT_EN
        @(posedge clk);
`endif
        #1;
        tests_run++;
        if (scoreboard.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: scoreboard empty", name);
        end else begin
            e = scoreboard.pop_front();
            if (sum !== e.exp_sum || carry !== e.exp_carry || overflow !== e.exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL %s: got sum=%h carry=%b ovf=%b, expected sum=%h carry=%b ovf=%b",
                         name, sum, carry, overflow, e.exp_sum, e.exp_carry, e.exp_ovf);
            end
        end
    endtask

    // Compare the outputs directly with constants, without the scoreboard.
    task automatic checkNow(input string name, input logic [31:0] es, input logic ec, input logic eo);
        tests_run++;
        if (sum !== es || carry !== ec || overflow !== eo) begin
            tests_failed++;
            $display("[TB] FAIL %s: got sum=%h carry=%b ovf=%b, expected sum=%h carry=%b ovf=%b",
                     name, sum, carry, overflow, es, ec, eo);
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        table_vec[0]  = '{32'd2,        32'd2,        1'b0, 32'd4,        1'b0, 1'b0};
        table_vec[1]  = '{32'd2,        32'd3,        1'b0, 32'd5,        1'b0, 1'b0};
        table_vec[2]  = '{32'd4,        32'd8,        1'b0, 32'd12,       1'b0, 1'b0};
        table_vec[3]  = '{32'hFFFFFFFE, 32'd2,        1'b0, 32'd0,        1'b1, 1'b0};
        table_vec[4]  = '{32'hFFFFFFFE, 32'd3,        1'b0, 32'd1,        1'b1, 1'b0};
        table_vec[5]  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0};
        table_vec[6]  = '{32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFB, 1'b1, 1'b0};
        table_vec[7]  = '{32'hFFFFFFFF, 32'd0,        1'b1, 32'd0,        1'b1, 1'b0};
        table_vec[8]  = '{32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1};
        table_vec[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'd0,        1'b1, 1'b1};
        table_vec[10] = '{32'd5,        32'hFFFFFFFC, 1'b1, 32'd2,        1'b1, 1'b0};

        // Reset: outputs clear regardless of operands in the registered build;
        // the combinational build ignores reset entirely.
        @(negedge clk);
        reset = 1'b1;
        inp0  = 32'd5;
        inp1  = 32'd6;
        cin   = 1'b0;
`ifdef FULL_ADDER_32BIT_REG_OUT_EN
        @(posedge clk);
        #1;
        checkNow("reset_clears", 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        checkNow("reset_hold_until_edge", 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkNow("after_release", 32'd11, 1'b0, 1'b0);
        @(negedge clk);
        inp0 = 32'hFFFFFFFF;
        inp1 = 32'd1;
        #1;
        checkNow("latency_old_value", 32'd11, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkNow("latency_new_value", 32'd0, 1'b1, 1'b0);
`else
        #1;
        checkNow("reset_ignored", 32'd11, 1'b0, 1'b0);
        reset = 1'b0;
`endif

        for (int i = 0; i < 11; i++) begin
            e.exp_sum   = table_vec[i].exp_sum;
            e.exp_carry = table_vec[i].exp_carry;
            e.exp_ovf   = table_vec[i].exp_ovf;
            applyStimulus(table_vec[i].a, table_vec[i].b, table_vec[i].ci, e);
            checkOutput($sformatf("table_%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i % 4 == 0) rb = ~ra;
            applyStimulus(ra, rb, rc, model(ra, rb, rc));
            checkOutput($sformatf("random_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
